i2c_master_arbiter: RTL and testbench

//  Shares one I2C_MASTER between NREQ on-chip requesters. Round-robin arbiter plus transaction sequencer.

---
 rtl/i2c_master_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Shares a single I2C_MASTER between NREQ on-chip requesters. A round-robin
//   arbiter picks one requester. A small sequencer then latches that
//   requester's transaction into the master, streams TX/RX bytes between the
//   owner and the master, and returns a completion pulse with status.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   Defined   : watchdog aborts XFER (Done + Err) after TIMEOUT cycles without M_Done.
//   Undefined : XFER waits for M_Done indefinitely; Err only flags NBytes == 0.
//
// Ports
//   Clk, RST          clock (rising edge) and asynchronous active-low reset
//   Req/ReqRorW       per-requester request level and direction (1 = read)
//   ReqAddr           packed slave addresses, requester i at [i*AL +: AL]
//   ReqNBytes         packed byte counts, requester i at [i*4 +: 4]
//   ReqTxData         packed current TX bytes, requester i at [i*8 +: 8]
//   Grant             one-hot owner of the master, 0 when idle
//   TxNext            pulse to the owner: TX byte consumed, present the next one
//   RxValid/RxData    pulse plus registered received byte for the owner
//   Done/Err          completion pulse to the owner, Err = rejected or aborted
//   Start, RorW, Slave_Address, NBytes, DataToSlave   drive the I2C_MASTER
//   DataFromSlave, M_ByteDone, M_Done                 status from the I2C_MASTER
module i2c_master_arbiter #(
  parameter int ADDRESSLENGTH = 8,
  parameter int NREQ          = 2,
  parameter int TIMEOUT       = 4096
) (
  input  logic                          Clk,
  input  logic                          RST,
  input  logic [NREQ-1:0]               Req,
  input  logic [NREQ-1:0]               ReqRorW,
  input  logic [NREQ*ADDRESSLENGTH-1:0] ReqAddr,
  input  logic [NREQ*4-1:0]             ReqNBytes,
  input  logic [NREQ*8-1:0]             ReqTxData,
  output logic [NREQ-1:0]               Grant,
  output logic [NREQ-1:0]               TxNext,
  output logic                          RxValid,
  output logic [7:0]                    RxData,
  output logic [NREQ-1:0]               Done,
  output logic                          Err,
  output logic                          Start,
  output logic                          RorW,
  output logic [ADDRESSLENGTH-1:0]      Slave_Address,
  output logic [3:0]                    NBytes,
  output logic [7:0]                    DataToSlave,
  input  logic [7:0]                    DataFromSlave,
  input  logic                          M_ByteDone,
  input  logic                          M_Done
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject configurations the rotation and watchdog logic cannot handle.
  if (NREQ < 2 || TIMEOUT < 2) begin : gParamCheck
    $error("i2c_master_arbiter needs NREQ >= 2 and TIMEOUT >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    XFER,
    DONE
  } stateT;

  stateT           state;
  logic [IDXW-1:0] rrPtr;
  logic [IDXW-1:0] grantIdx;
  logic [IDXW-1:0] winIdx;
  logic            winFound;

  logic [ADDRESSLENGTH-1:0] addrArr [NREQ];
  logic [3:0]               nbArr   [NREQ];
  logic [7:0]               txArr   [NREQ];

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
`endif

  // Unpack the flat requester buses so the owner can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : gUnpack
    assign addrArr[gi] = ReqAddr[gi*ADDRESSLENGTH +: ADDRESSLENGTH];
    assign nbArr[gi]   = ReqNBytes[gi*4 +: 4];
    assign txArr[gi]   = ReqTxData[gi*8 +: 8];
  end

  // Round-robin search: scan from the farthest offset down to the pointer so
  // the last hit written is the first set Req at or after rrPtr (wrapping).
  always_comb begin
    int              cand;
    logic [IDXW-1:0] candIdx;
    winFound = 1'b0;
    winIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(rrPtr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      candIdx = IDXW'(cand);
      if (Req[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  // The master sees the owner's live TX byte; Grant is zero when idle, so the
  // bus reads 0 outside a transaction.
  always_comb begin
    DataToSlave = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (Grant[i]) DataToSlave = DataToSlave | txArr[i];
    end
  end

  // Transaction sequencer. All pulse outputs default low every cycle and are
  // raised only on the transition that needs them, which keeps every pulse
  // exactly one cycle wide. Done/Err are set on entry to DONE so they are seen
  // during the DONE cycle, together with the cleared Grant.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      rrPtr         <= '0;
      grantIdx      <= '0;
      Grant         <= '0;
      TxNext        <= '0;
      RxValid       <= 1'b0;
      RxData        <= '0;
      Done          <= '0;
      Err           <= 1'b0;
      Start         <= 1'b0;
      RorW          <= 1'b0;
      Slave_Address <= '0;
      NBytes        <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timer         <= '0;
`endif
    end else begin
      Start   <= 1'b0;
      TxNext  <= '0;
      RxValid <= 1'b0;
      Done    <= '0;
      Err     <= 1'b0;
      case (state)
        IDLE: begin
          if (winFound) begin
            Grant         <= '0;
            Grant[winIdx] <= 1'b1;
            grantIdx      <= winIdx;
            state         <= GRANT;
          end
        end
        GRANT: begin
          RorW          <= ReqRorW[grantIdx];
          Slave_Address <= addrArr[grantIdx];
          NBytes        <= nbArr[grantIdx];
          if (nbArr[grantIdx] == 4'd0) begin
            Done[grantIdx] <= 1'b1;
            Err            <= 1'b1;
            Grant          <= '0;
            state          <= DONE;
          end else begin
            Start <= 1'b1;
            state <= START;
`ifdef I2C_ARB_TIMEOUT_EN
            timer <= '0;
`endif
          end
        end
        START: begin
          state <= XFER;
`ifdef I2C_ARB_TIMEOUT_EN
          // The Start cycle itself counts toward the watchdog window.
          timer <= TW'(1);
`endif
        end
        XFER: begin
          if (M_ByteDone) begin
            if (RorW) begin
              RxData  <= DataFromSlave;
              RxValid <= 1'b1;
            end else begin
              TxNext[grantIdx] <= 1'b1;
            end
          end
          if (M_Done) begin
            Done[grantIdx] <= 1'b1;
            Grant          <= '0;
            state          <= DONE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT - 1)) begin
            Done[grantIdx] <= 1'b1;
            Err            <= 1'b1;
            Grant          <= '0;
            state          <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        DONE: begin
          rrPtr <= (grantIdx == IDXW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter
//   Drives i2c_master_arbiter with three requesters and a behavioural I2C
//   master. Expected winners come from a round-robin pointer model, expected
//   bytes from per-requester byte lists held in the bench.
module tb_i2c_master_arbiter;

  localparam int AL = 8;
  localparam int NR = 3;

  logic            clk;
  logic            rstN;
  logic [NR-1:0]   req;
  logic [NR-1:0]   reqRorW;
  logic [NR*AL-1:0] reqAddr;
  logic [NR*4-1:0] reqNBytes;
  logic [NR*8-1:0] reqTxData;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   txNext;
  logic            rxValid;
  logic [7:0]      rxData;
  logic [NR-1:0]   done;
  logic            err;
  logic            start;
  logic            rorW;
  logic [AL-1:0]   slaveAddress;
  logic [3:0]      nBytes;
  logic [7:0]      dataToSlave;
  logic [7:0]      dataFromSlave;
  logic            mByteDone;
  logic            mDone;

  int checks = 0;
  int errors = 0;

  // Reference state: round-robin pointer plus each requester's transaction.
  int         ptr;
  bit         fRorW   [NR];
  logic [7:0] fAddr   [NR];
  int         fNb     [NR];
  logic [7:0] txBytes [NR][16];
  int         txIdx   [NR];

  i2c_master_arbiter #(
    .ADDRESSLENGTH(AL),
    .NREQ         (NR),
    .TIMEOUT      (16)
  ) dut (
    .Clk          (clk),
    .RST          (rstN),
    .Req          (req),
    .ReqRorW      (reqRorW),
    .ReqAddr      (reqAddr),
    .ReqNBytes    (reqNBytes),
    .ReqTxData    (reqTxData),
    .Grant        (grant),
    .TxNext       (txNext),
    .RxValid      (rxValid),
    .RxData       (rxData),
    .Done         (done),
    .Err          (err),
    .Start        (start),
    .RorW         (rorW),
    .Slave_Address(slaveAddress),
    .NBytes       (nBytes),
    .DataToSlave  (dataToSlave),
    .DataFromSlave(dataFromSlave),
    .M_ByteDone   (mByteDone),
    .M_Done       (mDone)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequencer wedges somewhere unbounded.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Push the bench's requester fields onto the flat DUT buses.
  task automatic applyStimulus();
    for (int r = 0; r < NR; r++) begin
      reqRorW[r]           = fRorW[r];
      reqAddr[r*AL +: AL]  = fAddr[r];
      reqNBytes[r*4 +: 4]  = 4'(fNb[r]);
      reqTxData[r*8 +: 8]  = txBytes[r][txIdx[r]];
    end
  endtask

  task automatic setRequest(input int r, input bit rw, input logic [7:0] addr, input int nb);
    fRorW[r] = rw;
    fAddr[r] = addr;
    fNb[r]   = nb;
    txIdx[r] = 0;
    for (int k = 0; k < 16; k++) txBytes[r][k] = 8'($urandom);
    req[r] = 1'b1;
    applyStimulus();
  endtask

  task automatic setRandomRequest(input int r);
    setRequest(r, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3));
  endtask

  function automatic int expectedWinner();
    for (int off = 0; off < NR; off++) begin
      if (req[(ptr + off) % NR]) return (ptr + off) % NR;
    end
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".grant"}, grant, 0);
    checkOutput({tag, ".txNext"}, txNext, 0);
    checkOutput({tag, ".rxValid"}, rxValid, 0);
    checkOutput({tag, ".rxData"}, rxData, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".err"}, err, 0);
    checkOutput({tag, ".start"}, start, 0);
    checkOutput({tag, ".rorW"}, rorW, 0);
    checkOutput({tag, ".addr"}, slaveAddress, 0);
    checkOutput({tag, ".nBytes"}, nBytes, 0);
    checkOutput({tag, ".dataToSlave"}, dataToSlave, 0);
  endtask

  // One full transaction with the behavioural master. Called at the negedge
  // where the pending requests are already driven. expWait is the number of
  // negedges until Grant shows (1 from a quiet IDLE, 2 right after a Done).
  // mode: 0 random, 1 last M_ByteDone coincides with M_Done, 2 separate.
  task automatic runTransaction(input int expWait, input int mode, output logic [NR-1:0] gotGrant);
    int         w;
    int         nb;
    int         waitN;
    int         gap;
    bit         rw;
    bit         coincide;
    logic [7:0] rxByte;
    w  = expectedWinner();
    if (w < 0) w = 0;
    nb = fNb[w];
    rw = fRorW[w];
    waitN = 0;
    do begin
      tick();
      waitN++;
    end while (grant == '0 && waitN < 50);
    gotGrant = grant;
    checkOutput("grantLatency", waitN, expWait);
    checkOutput("grantOwner", grant, 1 << w);
    checkOutput("grantDataMux", dataToSlave, txBytes[w][0]);
    if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
    tick();
    checkOutput("startPulse", start, (nb != 0) ? 1 : 0);
    checkOutput("latchRorW", rorW, rw);
    checkOutput("latchAddr", slaveAddress, fAddr[w]);
    checkOutput("latchNBytes", nBytes, nb);
    if (nb == 0) begin
      checkOutput("zeroDone", done, 1 << w);
      checkOutput("zeroErr", err, 1);
      checkOutput("zeroGrant", grant, 0);
    end else begin
      checkOutput("noEarlyDone", done, 0);
      coincide = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int k = 0; k < nb; k++) begin
        gap = (k == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
        repeat (gap) tick();
        #1;
        if (!rw) checkOutput("txByte", dataToSlave, txBytes[w][k]);
        rxByte        = 8'($urandom);
        dataFromSlave = rxByte;
        mByteDone     = 1'b1;
        mDone         = coincide && (k == nb - 1);
        tick();
        mByteDone = 1'b0;
        mDone     = 1'b0;
        checkOutput("startOnce", start, 0);
        checkOutput("txNext", txNext, rw ? 0 : (1 << w));
        checkOutput("rxValid", rxValid, rw);
        if (rw) checkOutput("rxData", rxData, rxByte);
        if (!rw) begin
          txIdx[w]++;
          applyStimulus();
        end
        if (!(coincide && (k == nb - 1))) checkOutput("doneHeld", done, 0);
      end
      if (!coincide) begin
        repeat ($urandom_range(0, 2)) tick();
        mDone = 1'b1;
        tick();
        mDone = 1'b0;
      end
      checkOutput("doneOwner", done, 1 << w);
      checkOutput("doneErr", err, 0);
      checkOutput("doneGrant", grant, 0);
    end
    ptr = (w + 1) % NR;
  endtask

  initial begin
    logic [NR-1:0] g;
    int            order [4];
    int            n;
    int            holdCount;

    order = '{0, 1, 0, 1};
    ptr   = 0;
    req   = '0;
    for (int r = 0; r < NR; r++) begin
      fRorW[r] = 1'b0;
      fAddr[r] = '0;
      fNb[r]   = 0;
      txIdx[r] = 0;
      for (int k = 0; k < 16; k++) txBytes[r][k] = '0;
    end
    applyStimulus();
    dataFromSlave = '0;
    mByteDone     = 1'b0;
    mDone         = 1'b0;
    rstN          = 1'b1;
    #3 rstN = 1'b0;

    // Reset state.
    tick();
    tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();

    // Single write of A5 to 0x0F from requester 0.
    $display("[TB] directed write");
    setRequest(0, 1'b0, 8'h0F, 1);
    txBytes[0][0] = 8'hA5;
    applyStimulus();
    runTransaction(1, 2, g);

    // Zero-length request is rejected without a Start.
    $display("[TB] zero-length reject");
    req[0] = 1'b0;
    setRequest(1, 1'b0, 8'h33, 0);
    runTransaction(2, 0, g);
    checkOutput("zeroOwner", g, 3'b010);

    // Two held 1-byte reads alternate.
    $display("[TB] fairness");
    req = '0;
    setRequest(0, 1'b1, 8'h20, 1);
    setRequest(1, 1'b1, 8'h21, 1);
    for (int i = 0; i < 4; i++) begin
      runTransaction(2, 0, g);
      checkOutput("fairOrder", g, 1 << order[i]);
      setRequest(order[i], 1'b1, fAddr[order[i]], 1);
    end

    // Two-byte read with coincident last byte while requester 1 waits.
    $display("[TB] coincident byte and done");
    req = '0;
    setRequest(0, 1'b1, 8'h40, 2);
    setRequest(1, 1'b0, 8'h41, 1);
    runTransaction(2, 1, g);
    checkOutput("coinOwner", g, 3'b001);
    req[0] = 1'b0;
    runTransaction(2, 0, g);
    checkOutput("coinNext", g, 3'b010);

    // Randomized traffic.
    $display("[TB] random traffic");
    req = '0;
    setRandomRequest(0);
    setRandomRequest(2);
    for (int t = 0; t < 60; t++) begin
      int w;
      w = expectedWinner();
      runTransaction((t == 0) ? 2 : 2, 0, g);
      if (w >= 0) begin
        if (req[w] && $urandom_range(0, 1) == 1) setRandomRequest(w);
        else req[w] = 1'b0;
      end
      for (int r = 0; r < NR; r++) begin
        if (r != w && !req[r] && $urandom_range(0, 9) < 4) setRandomRequest(r);
      end
      if (req == '0) setRandomRequest($urandom_range(0, NR - 1));
    end

    // Asynchronous reset in the middle of a transfer.
    $display("[TB] reset during transfer");
    req = '0;
    setRequest(1, 1'b0, 8'h44, 3);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 50);
    checkOutput("rstGrant", grant, 3'b010);
    tick();
    checkOutput("rstStart", start, 1);
    tick();
    tick();
    #2 rstN = 1'b0;
    #1;
    checkAllZero("rstAsync");
    tick();
    tick();
    setRequest(0, 1'b1, 8'h12, 1);
    setRequest(1, 1'b0, 8'h44, 3);
    ptr  = 0;
    rstN = 1'b1;
    runTransaction(1, 0, g);
    checkOutput("rstRestartOwner", g, 3'b001);
    req[0] = 1'b0;
    runTransaction(2, 0, g);
    checkOutput("rstSecondOwner", g, 3'b010);

    // Master never finishes.
    $display("[TB] missing M_Done");
    req = '0;
    setRequest(2, 1'b0, 8'h5A, 2);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 50);
    checkOutput("hangGrant", grant, 3'b100);
    tick();
    checkOutput("hangStart", start, 1);
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (done == '0 && n < 40);
    checkOutput("timeoutLatency", n, 16);
    checkOutput("timeoutDone", done, 3'b100);
    checkOutput("timeoutErr", err, 1);
`else
    holdCount = 0;
    repeat (100) begin
      tick();
      if (grant == 3'b100 && done == '0) holdCount++;
    end
    checkOutput("grantHold", holdCount, 100);
    mDone = 1'b1;
    tick();
    mDone = 1'b0;
    checkOutput("lateDone", done, 3'b100);
    checkOutput("lateErr", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
